// File: rtl/async_ram_ctrl.sv
// Controller for an 8x16 asynchronous RAM on a shared tri-state data bus.
// Each access runs a fixed setup / strobe / hold timing sequence.
module async_ram_ctrl #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_write_in,
    input  logic [2:0]  req_addr_in,
    input  logic [15:0] req_wdata_in,
    output logic        rsp_valid_out,
    output logic [15:0] rsp_rdata_out,
    output logic        ram_we_out,
    output logic        ram_enable_out,
    output logic [2:0]  ram_addr_out,
    inout  wire  [15:0] ram_data
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } state_t;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        write_q, write_n;
    logic [15:0] wdata_q;
    logic        drive_q;
    logic        accept;

    assign req_ready_out = (state == IDLE) && !rst_in;
    assign accept        = req_valid_in && req_ready_out;
    assign ram_data      = drive_q ? wdata_q : 'z;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        write_n = write_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SETUP;
                    cnt_n   = SETUP_LD;
                    write_n = req_write_in;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_n = STROBE;
                    cnt_n   = STROBE_LD;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    if (write_q) begin
                        state_n = HOLD;
                        cnt_n   = HOLD_LD;
                    end else begin
                        state_n = RESP;
                    end
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - 4'd1;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Bus-facing outputs are registered from the next state so they align with it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            cnt            <= '0;
            write_q        <= 1'b0;
            wdata_q        <= '0;
            drive_q        <= 1'b0;
            ram_addr_out   <= '0;
            ram_we_out     <= 1'b0;
            ram_enable_out <= 1'b0;
            rsp_valid_out  <= 1'b0;
            rsp_rdata_out  <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            write_q <= write_n;
            if (accept) begin
                ram_addr_out <= req_addr_in;
                wdata_q      <= req_wdata_in;
            end
            ram_we_out     <= (state_n == STROBE) && write_n;
            ram_enable_out <= (state_n == STROBE) && !write_n;
            drive_q        <= write_n && (state_n inside {SETUP, STROBE, HOLD});
            rsp_valid_out  <= (state_n == RESP);
            if (state == STROBE && state_n == RESP)
                rsp_rdata_out <= ram_data;
        end
    end

endmodule

// File: tb/tb_async_ram_ctrl.sv
// Directed bench: default-timing instance and a 3/1/2-timing instance,
// each with a behavioural asynchronous RAM on a pulled-down data bus.
module tb_async_ram_ctrl;

    logic clk = 1'b0;
    logic rst;

    logic        a_valid, a_ready, a_write, a_rvalid, a_we, a_en;
    logic [2:0]  a_addr, a_raddr;
    logic [15:0] a_wdata, a_rdata;
    tri0  [15:0] a_bus;

    logic        b_valid, b_ready, b_write, b_rvalid, b_we, b_en;
    logic [2:0]  b_addr, b_raddr;
    logic [15:0] b_wdata, b_rdata;
    tri0  [15:0] b_bus;

    logic [15:0] mem_a [8] = '{default: 16'h0000};
    logic [15:0] mem_b [8] = '{default: 16'h0000};

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    async_ram_ctrl dut_a (
        .clk_in(clk), .rst_in(rst),
        .req_valid_in(a_valid), .req_ready_out(a_ready),
        .req_write_in(a_write), .req_addr_in(a_addr), .req_wdata_in(a_wdata),
        .rsp_valid_out(a_rvalid), .rsp_rdata_out(a_rdata),
        .ram_we_out(a_we), .ram_enable_out(a_en),
        .ram_addr_out(a_raddr), .ram_data(a_bus)
    );

    async_ram_ctrl #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) dut_b (
        .clk_in(clk), .rst_in(rst),
        .req_valid_in(b_valid), .req_ready_out(b_ready),
        .req_write_in(b_write), .req_addr_in(b_addr), .req_wdata_in(b_wdata),
        .rsp_valid_out(b_rvalid), .rsp_rdata_out(b_rdata),
        .ram_we_out(b_we), .ram_enable_out(b_en),
        .ram_addr_out(b_raddr), .ram_data(b_bus)
    );

    // RAM models: drive the bus on read enable, capture while the write strobe is high.
    assign a_bus = (a_en && !a_we) ? mem_a[a_raddr] : 'z;
    assign b_bus = (b_en && !b_we) ? mem_b[b_raddr] : 'z;
    always @(posedge clk) if (a_we) mem_a[a_raddr] <= a_bus;
    always @(posedge clk) if (b_we) mem_b[b_raddr] <= b_bus;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h, expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        check("no_overlap_a", 16'(a_we & a_en), 16'h0);
        check("no_overlap_b", 16'(b_we & b_en), 16'h0);
        if (a_en) check("bus_owned_by_ram_a", a_bus, mem_a[a_raddr]);
        if (b_en) check("bus_owned_by_ram_b", b_bus, mem_b[b_raddr]);
    end

    task automatic cyc(input bit sel_b, input string tag, input bit rdy, input bit we,
                       input bit en, input bit vld, input logic [2:0] addr,
                       input logic [15:0] data, input logic [15:0] rdata);
        @(negedge clk);
        check({tag, ".ready"}, 16'(sel_b ? b_ready  : a_ready),  16'(rdy));
        check({tag, ".we"},    16'(sel_b ? b_we     : a_we),     16'(we));
        check({tag, ".en"},    16'(sel_b ? b_en     : a_en),     16'(en));
        check({tag, ".rvld"},  16'(sel_b ? b_rvalid : a_rvalid), 16'(vld));
        check({tag, ".addr"},  16'(sel_b ? b_raddr  : a_raddr),  16'(addr));
        check({tag, ".bus"},   sel_b ? b_bus   : a_bus,   data);
        check({tag, ".rdata"}, sel_b ? b_rdata : a_rdata, rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_valid = 0; a_write = 0; a_addr = '0; a_wdata = '0;
        b_valid = 0; b_write = 0; b_addr = '0; b_wdata = '0;
        repeat (2) @(posedge clk);
        cyc(0, "rst_a", 0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000);
        cyc(1, "rst_b", 0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000);

        // Write addr 3 = A5C3, default timing
        rst = 1'b0;
        a_valid = 1; a_write = 1; a_addr = 3'd3; a_wdata = 16'hA5C3;
        #1 check("w3_c0.ready", 16'(a_ready), 16'h1);
        cyc(0, "w3_c1", 0, 0, 0, 0, 3'd3, 16'hA5C3, 16'h0000);
        a_valid = 0; a_write = 0; a_addr = 3'd6; a_wdata = 16'h1111;
        cyc(0, "w3_c2", 0, 1, 0, 0, 3'd3, 16'hA5C3, 16'h0000);
        cyc(0, "w3_c3", 0, 1, 0, 0, 3'd3, 16'hA5C3, 16'h0000);
        cyc(0, "w3_c4", 0, 0, 0, 0, 3'd3, 16'hA5C3, 16'h0000);
        cyc(0, "w3_c5", 1, 0, 0, 0, 3'd3, 16'h0000, 16'h0000);

        // Read addr 3
        a_valid = 1; a_write = 0; a_addr = 3'd3;
        cyc(0, "r3_c1", 0, 0, 0, 0, 3'd3, 16'h0000, 16'h0000);
        a_valid = 0; a_addr = 3'd0;
        cyc(0, "r3_c2", 0, 0, 1, 0, 3'd3, 16'hA5C3, 16'h0000);
        cyc(0, "r3_c3", 0, 0, 1, 0, 3'd3, 16'hA5C3, 16'h0000);
        cyc(0, "r3_c4", 0, 0, 0, 1, 3'd3, 16'h0000, 16'hA5C3);
        cyc(0, "r3_c5", 1, 0, 0, 0, 3'd3, 16'h0000, 16'hA5C3);

        // Back-to-back write then read of addr 7, valid held high throughout
        a_valid = 1; a_write = 1; a_addr = 3'd7; a_wdata = 16'hFFFF;
        cyc(0, "bw_c1", 0, 0, 0, 0, 3'd7, 16'hFFFF, 16'hA5C3);
        a_write = 0;
        cyc(0, "bw_c2", 0, 1, 0, 0, 3'd7, 16'hFFFF, 16'hA5C3);
        cyc(0, "bw_c3", 0, 1, 0, 0, 3'd7, 16'hFFFF, 16'hA5C3);
        cyc(0, "bw_c4", 0, 0, 0, 0, 3'd7, 16'hFFFF, 16'hA5C3);
        cyc(0, "bw_c5", 1, 0, 0, 0, 3'd7, 16'h0000, 16'hA5C3);
        cyc(0, "br_c1", 0, 0, 0, 0, 3'd7, 16'h0000, 16'hA5C3);
        a_valid = 0;
        cyc(0, "br_c2", 0, 0, 1, 0, 3'd7, 16'hFFFF, 16'hA5C3);
        cyc(0, "br_c3", 0, 0, 1, 0, 3'd7, 16'hFFFF, 16'hA5C3);
        cyc(0, "br_c4", 0, 0, 0, 1, 3'd7, 16'h0000, 16'hFFFF);
        cyc(0, "br_c5", 1, 0, 0, 0, 3'd7, 16'h0000, 16'hFFFF);

        // Reset during the second strobe cycle of a read aborts it
        a_valid = 1; a_write = 0; a_addr = 3'd3;
        cyc(0, "ab_c1", 0, 0, 0, 0, 3'd3, 16'h0000, 16'hFFFF);
        a_valid = 0;
        cyc(0, "ab_c2", 0, 0, 1, 0, 3'd3, 16'hA5C3, 16'hFFFF);
        cyc(0, "ab_c3", 0, 0, 1, 0, 3'd3, 16'hA5C3, 16'hFFFF);
        rst = 1'b1;
        cyc(0, "ab_c4", 0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000);
        rst = 1'b0;
        cyc(0, "ab_c5", 1, 0, 0, 0, 3'd0, 16'h0000, 16'h0000);
        cyc(0, "ab_c6", 1, 0, 0, 0, 3'd0, 16'h0000, 16'h0000);

        // SETUP=3 STROBE=1 HOLD=2: write occupancy 6, read latency 5
        b_valid = 1; b_write = 1; b_addr = 3'd5; b_wdata = 16'h1234;
        cyc(1, "bw5_c1", 0, 0, 0, 0, 3'd5, 16'h1234, 16'h0000);
        b_valid = 0; b_wdata = 16'h0000;
        cyc(1, "bw5_c2", 0, 0, 0, 0, 3'd5, 16'h1234, 16'h0000);
        cyc(1, "bw5_c3", 0, 0, 0, 0, 3'd5, 16'h1234, 16'h0000);
        cyc(1, "bw5_c4", 0, 1, 0, 0, 3'd5, 16'h1234, 16'h0000);
        cyc(1, "bw5_c5", 0, 0, 0, 0, 3'd5, 16'h1234, 16'h0000);
        cyc(1, "bw5_c6", 0, 0, 0, 0, 3'd5, 16'h1234, 16'h0000);
        cyc(1, "bw5_c7", 1, 0, 0, 0, 3'd5, 16'h0000, 16'h0000);

        b_valid = 1; b_write = 0; b_addr = 3'd5;
        cyc(1, "br5_c1", 0, 0, 0, 0, 3'd5, 16'h0000, 16'h0000);
        b_valid = 0;
        cyc(1, "br5_c2", 0, 0, 0, 0, 3'd5, 16'h0000, 16'h0000);
        cyc(1, "br5_c3", 0, 0, 0, 0, 3'd5, 16'h0000, 16'h0000);
        cyc(1, "br5_c4", 0, 0, 1, 0, 3'd5, 16'h1234, 16'h0000);
        cyc(1, "br5_c5", 0, 0, 0, 1, 3'd5, 16'h0000, 16'h1234);
        cyc(1, "br5_c6", 1, 0, 0, 0, 3'd5, 16'h0000, 16'h1234);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/async_ram_ctrl.md
ASYNC_RAM_CTRL -- requirements
Module: async_ram_ctrl

Interface
REQ-001 Parameter SETUP_CYC, default 1, cycles address/data are stable before the strobe; legal range 1..15.
REQ-002 Parameter STROBE_CYC, default 2, cycles ram_we_out or ram_enable_out is held high; legal range 1..15.
REQ-003 Parameter HOLD_CYC, default 1, cycles address/data remain stable after a write strobe; legal range 1..15.
REQ-004 clk_in  input  1  single clock; all state updates on rising edge.
REQ-005 rst_in  input  1  synchronous, active-high reset.
REQ-006 req_valid_in  input  1  request present.
REQ-007 req_ready_out  output  1  controller can accept a request this cycle.
REQ-008 req_write_in  input  1  1 = write, 0 = read; sampled with the request.
REQ-009 req_addr_in  input  3  word address, 0..7.
REQ-010 req_wdata_in  input  16  write data.
REQ-011 rsp_valid_out  output  1  one-cycle pulse; read data valid.
REQ-012 rsp_rdata_out  output  16  read data; holds last value between pulses.
REQ-013 ram_we_out  output  1  write strobe to the 8x16 asynchronous RAM.
REQ-014 ram_enable_out  output  1  read enable to the RAM; RAM drives ram_data only while this is high and ram_we_out is low.
REQ-015 ram_addr_out  output  3  RAM address.
REQ-016 ram_data  inout  16  shared tri-state data bus to the RAM.

Function
REQ-017 Request accepted in the cycle where req_valid_in and req_ready_out are both 1; addr, write flag and wdata are registered then; later input changes have no effect.
REQ-018 req_ready_out = 1 only in IDLE; no request queueing.
REQ-019 FSM states: IDLE, SETUP, STROBE, HOLD, RESP; one down-counter times SETUP, STROBE and HOLD.
REQ-020 IDLE -> SETUP on accept; SETUP lasts SETUP_CYC cycles, then STROBE; STROBE lasts STROBE_CYC cycles.
REQ-021 Write path: STROBE -> HOLD (HOLD_CYC cycles) -> IDLE; no response pulse for writes.
REQ-022 Read path: STROBE -> RESP (1 cycle) -> IDLE; HOLD is not used for reads.
REQ-023 ram_addr_out = registered address in SETUP, STROBE, HOLD, RESP; unchanged (last value) in IDLE.
REQ-024 ram_we_out = 1 only in STROBE of a write; ram_enable_out = 1 only in STROBE of a read; both registered, never both 1.
REQ-025 Controller drives ram_data with registered wdata only in SETUP, STROBE and HOLD of a write; otherwise ram_data is driven to high impedance by the controller.
REQ-026 Read data captured from ram_data on the clock edge ending the last STROBE cycle; rsp_rdata_out updated and rsp_valid_out = 1 during RESP.
REQ-027 Write occupancy = SETUP_CYC+STROBE_CYC+HOLD_CYC cycles after accept; read accept-to-rsp_valid_out latency = SETUP_CYC+STROBE_CYC+1 cycles; next accept possible the cycle after returning to IDLE.
REQ-028 Bus turnaround: at least one cycle with neither side driving ram_data between a write's HOLD and a following read's STROBE (guaranteed by IDLE + SETUP).
REQ-029 Addresses 0..7 have no special case; no wrap or range check needed.

Reset
REQ-030 While rst_in = 1 at a rising edge: state -> IDLE, counter -> 0, ram_we_out = 0, ram_enable_out = 0, ram_addr_out = 0, rsp_valid_out = 0, rsp_rdata_out = 0, ram_data released; req_ready_out = 0 while rst_in = 1, 1 on the first cycle after.
REQ-031 Reset in any non-IDLE state aborts the transaction: no response pulse, strobes low and bus released from the next edge.

Verification
REQ-032 Defaults; write addr 3 data 16'hA5C3 -> ram_we_out high exactly 2 cycles, ram_data = 16'hA5C3 for 4 cycles, req_ready_out low 4 cycles.
REQ-033 After REQ-032, read addr 3 -> ram_enable_out high 2 cycles, rsp_valid_out pulses 4 cycles after accept with rsp_rdata_out = 16'hA5C3.
REQ-034 Back-to-back: write addr 7 = 16'hFFFF, then read addr 7 with req_valid_in held high -> second accept in the cycle after write HOLD ends; ram_we_out/ram_enable_out never overlap; read returns 16'hFFFF.
REQ-035 rst_in asserted during the second STROBE cycle of a read -> next cycle strobes 0, ram_data high-Z, no rsp_valid_out, req_ready_out 1 after reset release.
REQ-036 SETUP_CYC=3, STROBE_CYC=1, HOLD_CYC=2: write occupancy 6 cycles, read latency 5 cycles, verified per cycle.
REQ-037 Assertions throughout: never (ram_we_out & ram_enable_out); controller never drives ram_data while ram_enable_out = 1.
